// File: rtl/cvfpu_issue_ctrl.sv
// In-order issue / out-of-order capture / in-order retire controller for the vector FPU.
// Optional sticky exception accumulator enabled by defining CVFPU_ISSUE_STATUS_ACC_EN.
module cvfpu_issue_ctrl #(
    parameter int WIDTH     = 512,
    parameter int LANES     = 16,
    parameter int TAG_WIDTH = 2,
    parameter int ID_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_bits_operands_0,
    input  logic [WIDTH-1:0]     in_bits_operands_1,
    input  logic [WIDTH-1:0]     in_bits_operands_2,
    input  logic [2:0]           in_bits_roundingMode,
    input  logic [4:0]           in_bits_op,
    input  logic [2:0]           in_bits_srcFormat,
    input  logic [2:0]           in_bits_dstFormat,
    input  logic [1:0]           in_bits_intFormat,
    input  logic [LANES-1:0]     in_bits_simdMask,
    input  logic [ID_WIDTH-1:0]  in_bits_id,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [WIDTH-1:0]     req_bits_operands_0,
    output logic [WIDTH-1:0]     req_bits_operands_1,
    output logic [WIDTH-1:0]     req_bits_operands_2,
    output logic [2:0]           req_bits_roundingMode,
    output logic [4:0]           req_bits_op,
    output logic [2:0]           req_bits_srcFormat,
    output logic [2:0]           req_bits_dstFormat,
    output logic [1:0]           req_bits_intFormat,
    output logic [LANES-1:0]     req_bits_simdMask,
    output logic [TAG_WIDTH-1:0] req_bits_tag,
    input  logic                 resp_valid,
    output logic                 resp_ready,
    input  logic [WIDTH-1:0]     resp_bits_result,
    input  logic [4:0]           resp_bits_status,
    input  logic [TAG_WIDTH-1:0] resp_bits_tag,
    output logic                 flush,
    input  logic                 busy,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [WIDTH-1:0]     wb_bits_result,
    output logic [4:0]           wb_bits_status,
    output logic [ID_WIDTH-1:0]  wb_bits_id,
    output logic [4:0]           status_acc,
    input  logic                 status_clear
);
    localparam int DEPTH = 1 << TAG_WIDTH;

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [TAG_WIDTH-1:0]  alloc_ptr, retire_ptr;
    logic [TAG_WIDTH:0]    count;
    logic [DEPTH-1:0]      alloc, done;
    logic [ID_WIDTH-1:0]   rob_id     [DEPTH];
    logic [WIDTH-1:0]      rob_result [DEPTH];
    logic [4:0]            rob_status [DEPTH];

    logic run, not_full, issue_fire, capture, wb_fire;

    assign run        = (state == RUN);
    assign not_full   = (count < (TAG_WIDTH+1)'(DEPTH));
    assign req_valid  = in_valid & run & not_full;
    assign in_ready   = req_ready & run & not_full;
    assign issue_fire = in_valid & in_ready;
    assign resp_ready = 1'b1;
    assign capture    = run & resp_valid & alloc[resp_bits_tag] & ~done[resp_bits_tag];
    assign wb_valid   = run & done[retire_ptr];
    assign wb_fire    = wb_valid & wb_ready;

    assign req_bits_operands_0   = in_bits_operands_0;
    assign req_bits_operands_1   = in_bits_operands_1;
    assign req_bits_operands_2   = in_bits_operands_2;
    assign req_bits_roundingMode = in_bits_roundingMode;
    assign req_bits_op           = in_bits_op;
    assign req_bits_srcFormat    = in_bits_srcFormat;
    assign req_bits_dstFormat    = in_bits_dstFormat;
    assign req_bits_intFormat    = in_bits_intFormat;
    assign req_bits_simdMask     = in_bits_simdMask;
    assign req_bits_tag          = alloc_ptr;

    assign wb_bits_result = rob_result[retire_ptr];
    assign wb_bits_status = rob_status[retire_ptr];
    assign wb_bits_id     = rob_id[retire_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        flush      = 1'b0;
        flush_done = 1'b0;
        case (state)
            RUN:   if (flush_req) state_nxt = FLUSH;
            FLUSH: begin
                flush     = 1'b1;
                state_nxt = DRAIN;
            end
            DRAIN: if (!busy && !resp_valid) begin
                flush_done = 1'b1;
                state_nxt  = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // ROB control bits, pointers and occupancy; a wb fire on the RUN->FLUSH edge still retires
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alloc_ptr  <= '0;
            retire_ptr <= '0;
            count      <= '0;
            alloc      <= '0;
            done       <= '0;
        end else if (state == FLUSH) begin
            alloc_ptr  <= '0;
            retire_ptr <= '0;
            count      <= '0;
            alloc      <= '0;
            done       <= '0;
        end else begin
            if (issue_fire) begin
                alloc[alloc_ptr] <= 1'b1;
                done[alloc_ptr]  <= 1'b0;
                alloc_ptr        <= alloc_ptr + TAG_WIDTH'(1);
            end
            if (capture) done[resp_bits_tag] <= 1'b1;
            if (wb_fire) begin
                alloc[retire_ptr] <= 1'b0;
                done[retire_ptr]  <= 1'b0;
                retire_ptr        <= retire_ptr + TAG_WIDTH'(1);
            end
            count <= count + (TAG_WIDTH+1)'(issue_fire) - (TAG_WIDTH+1)'(wb_fire);
        end
    end

    // ROB payload needs no reset: it is only observed behind the done bit
    always_ff @(posedge clock) begin
        if (issue_fire) rob_id[alloc_ptr] <= in_bits_id;
        if (capture) begin
            rob_result[resp_bits_tag] <= resp_bits_result;
            rob_status[resp_bits_tag] <= resp_bits_status;
        end
    end

`ifdef CVFPU_ISSUE_STATUS_ACC_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)             status_acc <= '0;
        else if (status_clear) status_acc <= '0;
        else if (wb_fire)      status_acc <= status_acc | wb_bits_status;
    end
`else
    logic unused_status_clear;
    assign unused_status_clear = status_clear;
    assign status_acc          = '0;
`endif

    resp_tag_live: assert property (@(posedge clock) disable iff (reset)
        (run && resp_valid) |-> (alloc[resp_bits_tag] && !done[resp_bits_tag]));

endmodule

// File: doc/cvfpu_issue_ctrl.md
# cvfpu_issue_ctrl

Requester-side controller for the vector FPU wrapper's req/resp handshake. Accepts FP operations from the warp pipeline and assigns each one an in-flight tag. Drives the FPU request channel and captures responses, which may return out of order. It then retires results in program order to the writeback stage. It also sequences FPU flushes and drains stale in-flight work.

## Interface
- WIDTH, 512, operand/result width in bits
- LANES, 16, SIMD lanes, equal to the simdMask width
- TAG_WIDTH, 2, FPU tag width; reorder depth DEPTH = 2^TAG_WIDTH
- ID_WIDTH, 8, opaque upstream instruction ID carried to writeback

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- in_valid / in_ready  in / out  1  upstream op handshake
- in_bits_operands_0/1/2  in  WIDTH  source operands
- in_bits_roundingMode  in  3; in_bits_op  in  5 (op_mod is the LSB); in_bits_srcFormat / in_bits_dstFormat  in  3; in_bits_intFormat  in  2
- in_bits_simdMask  in  LANES; in_bits_id  in  ID_WIDTH
- req_valid / req_ready  out / in  1  FPU request handshake
- req_bits_* (operands_0/1/2, roundingMode, op, srcFormat, dstFormat, intFormat, simdMask)  out  widths as the matching in_bits_*
- req_bits_tag  out  TAG_WIDTH
- resp_valid / resp_ready  in / out  1; resp_bits_result  in  WIDTH; resp_bits_status  in  5; resp_bits_tag  in  TAG_WIDTH
- flush  out  1  FPU flush pulse
- busy  in  1  FPU busy indication
- flush_req  in  1  pipeline kill request; flush_done  out  1  one-cycle pulse when RUN resumes
- wb_valid / wb_ready  out / in  1; wb_bits_result  out  WIDTH; wb_bits_status  out  5; wb_bits_id  out  ID_WIDTH
- status_acc  out  5  sticky accumulated exception flags; status_clear  in  1

## Operation
- Reorder buffer (ROB) has DEPTH entries indexed by tag. Per entry: alloc bit, done bit, id, result, status.
- Pointers alloc_ptr and retire_ptr are TAG_WIDTH bits and wrap mod DEPTH. The count register is TAG_WIDTH+1 bits.
- Issue:
  - req_bits_* = in_bits_* combinationally; req_bits_tag = alloc_ptr.
  - req_valid = in_valid & state==RUN & count<DEPTH.
  - in_ready = req_ready & state==RUN & count<DEPTH.
  - On fire: entry[alloc_ptr].alloc=1, done=0, id captured; alloc_ptr++, count++.
- Capture:
  - resp_ready = 1 in every state.
  - In RUN, when resp_valid and entry[resp_bits_tag].alloc & !done: store result and status, set done=1.
  - A response to a non-allocated or already-done tag is dropped; a simulation assertion fires.
- Retire:
  - wb_valid = entry[retire_ptr].done; wb_bits_* are driven from that entry.
  - On wb fire: clear alloc and done, retire_ptr++, count--.
- Alloc and retire in the same cycle leave count unchanged. Fullness is evaluated on the registered count, so a slot freed by retire cannot be reused in the same cycle.
- FSM states:
  - RUN --flush_req--> FLUSH.
  - FLUSH (1 cycle): flush=1; all alloc/done bits cleared; pointers and count set to 0; then DRAIN.
  - DRAIN: responses are accepted and discarded; in_ready=0; wb_valid=0. Move to RUN on the first cycle busy==0 & resp_valid==0, pulsing flush_done.
- flush_req in FLUSH or DRAIN is ignored. flush_req outside RUN has no effect beyond the current flush sequence.
- A wb fire in the same cycle as the RUN->FLUSH transition completes normally; that entry retires before the clear.

## Timing
- Issue adds zero latency (combinational pass-through).
- Response-to-writeback latency is 1 cycle minimum: capture on edge N, wb_valid in cycle N+1.
- flush_req to flush pulse: 1 cycle. Minimum flush_req to flush_done: 2 cycles.
- Reset values: state=RUN, pointers=0, count=0, every entry's alloc and done=0, flush=0, wb_valid=0, flush_done=0, status_acc=0.
- Immediately after reset, req_valid/in_ready follow the combinational equations.

## Configuration
- CVFPU_ISSUE_STATUS_ACC_EN defined:
  - status_acc ORs in wb_bits_status on every wb fire.
  - status_clear zeroes status_acc. Clear takes priority over a same-cycle accumulate.
  - FLUSH does not clear status_acc.
- Undefined: status_acc is tied to 0, status_clear is ignored, and no accumulator register exists.

## Test plan
- Single op, id=0x11, FPU responds 3 cycles later with result=A, status=0x01 -> req_bits_tag=0; wb_valid one cycle after the response with result A, status 0x01, id 0x11.
- Four issues (ids 1..4, tags 0..3), responses in order 2,0,3,1 -> wb emits ids 1,2,3,4 in order. A 5th op is blocked (in_ready=0) until the first retire.
- wb_ready held low with the ROB full, FPU req_ready=1 -> in_ready=0, req_valid=0, count stays 4. Release wb_ready -> one retire per cycle and in_ready rises the cycle after the first retire.
- Two ops in flight, flush_req asserted, FPU returns both responses during DRAIN with busy=1 for 3 cycles -> flush=1 for exactly 1 cycle, no wb_valid, flush_done pulses after busy drops, next issue uses tag 0.
- Macro on: retire statuses 0x01 then 0x10 -> status_acc=0x11; status_clear in the same cycle as a retire with 0x04 -> status_acc=0x00.
- Async reset mid-operation with 3 entries in flight -> all outputs at reset values immediately; first post-reset issue gets tag 0.
